// File: rtl/pcm_rx_framer_pkg.sv
// Shared MCAC datapath types: PCM word layout and companding-law encodings.
// Combinational definitions only; no latency or backpressure.
package mcac_pkg;

  localparam int PCM_W = 8;

  localparam logic LAW_A = 1'b1;
  localparam logic LAW_U = 1'b0;

  typedef struct packed {
    logic             law;
    logic [PCM_W-1:0] code;
  } pcm_word_t;

  function automatic int frame_bits(input int slots);
    return slots * PCM_W;
  endfunction

endpackage

// File: rtl/pcm_rx_framer_if.sv
// Valid/ready handshake carrying one PCM codeword plus its law tag toward EXPAND.
// Data must hold steady while valid is high and ready is low.
interface pcm_rx_framer_if;
  import mcac_pkg::*;

  logic             out_valid;
  logic             out_ready;
  logic [PCM_W-1:0] out_s;
  logic             out_law;

  modport master (output out_valid, output out_s, output out_law, input out_ready);
  modport slave  (input out_valid, input out_s, input out_law, output out_ready);

endinterface

// File: rtl/pcm_rx_framer_fifo.sv
// Two-entry first-word-fall-through FIFO of PCM words; head is visible the cycle after push.
// When full, a push is taken only if a pop lands in the same cycle.
module pcm_fifo2
  import mcac_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  input  logic      push,
  input  logic      pop,
  input  pcm_word_t din,
  output logic      full,
  output logic      empty,
  output pcm_word_t head
);

  pcm_word_t  mem [2];
  logic       wr_ptr;
  logic       rd_ptr;
  logic [1:0] count;
  logic       do_pop;
  logic       do_push;

  assign full    = (count == 2'd2);
  assign empty   = (count == 2'd0);
  assign head    = mem[rd_ptr];
  assign do_pop  = pop && !empty;
  // The freed slot of a same-cycle pop makes room for a push into a full FIFO.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/pcm_rx_framer.sv
// TDM serial PCM framer: captures one timeslot's codeword, tags its law, queues it for EXPAND.
// Word is valid 1 clk after the slot LSB strobe; a full queue without a pop drops the word and flags overrun.
module pcm_rx_framer
  import mcac_pkg::*;
#(
  parameter int SLOTS = 32,
  parameter int SLOT  = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    bclk_en,
  input  logic                    fs,
  input  logic                    sdin,
  input  logic                    law_in,
  input  logic                    clr_ovr,
  pcm_rx_framer_if.master         pcm,
  output logic                    locked,
  output logic                    sync_err,
  output logic                    overrun
);

  localparam int FRAME_BITS = frame_bits(SLOTS);
  localparam int CW         = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;
  localparam logic [CW-1:0] LAST = CW'(FRAME_BITS - 1);

  logic [CW-1:0]    bcnt;
  logic [CW-1:0]    pos;
  logic [CW:0]      rel;
  logic             in_win;
  logic             win_first;
  logic             win_last;
  logic             capture;
  logic             bad_fs;
  logic             push;
  logic             pop;
  logic             ovr_set;
  logic [PCM_W-2:0] sr;
  logic             law_q;
  logic             fifo_full;
  logic             fifo_empty;
  pcm_word_t        word;
  pcm_word_t        head;

  always_comb begin
    pos       = (fs || bcnt == LAST) ? '0 : bcnt + CW'(1);
    // One extra bit keeps positions before the window from aliasing into it.
    rel       = {1'b0, pos} - (CW+1)'(SLOT * PCM_W);
    in_win    = rel < (CW+1)'(PCM_W);
    win_first = (rel == '0);
    win_last  = (rel == (CW+1)'(PCM_W - 1));
    capture   = bclk_en && (locked || fs);
    bad_fs    = bclk_en && fs && locked && (bcnt != LAST);
    push      = capture && win_last;
    pop       = pcm.out_valid && pcm.out_ready;
    ovr_set   = push && fifo_full && !pop;
    word.law  = law_q;
    word.code = {sr, sdin};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bcnt     <= '0;
      locked   <= 1'b0;
      sync_err <= 1'b0;
      sr       <= '0;
      law_q    <= LAW_U;
      overrun  <= 1'b0;
    end else begin
      sync_err <= bad_fs;
      if (bclk_en) begin
        bcnt <= pos;
        if (fs) begin
          locked <= 1'b1;
        end
      end
      if (bad_fs) begin
        sr <= '0;
      end
      if (capture && in_win) begin
        sr <= {sr[PCM_W-3:0], sdin};
        if (win_first) begin
          law_q <= law_in;
        end
      end
      if (ovr_set) begin
        overrun <= 1'b1;
      end else if (clr_ovr) begin
        overrun <= 1'b0;
      end
    end
  end

  pcm_fifo2 u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (word),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (head)
  );

  assign pcm.out_valid = !fifo_empty;
  assign pcm.out_s     = head.code;
  assign pcm.out_law   = head.law;

endmodule

// File: tb/tb_pcm_rx_framer.sv
// Randomized bench for pcm_rx_framer (SLOTS=4, SLOT=2) against a frame-level reference model.
module tb_pcm_rx_framer;
  import mcac_pkg::*;

  logic clk = 1'b0;
  logic reset, bclk_en, fs, sdin, law_in, clr_ovr;
  logic locked, sync_err, overrun;

  pcm_rx_framer_if bus ();

  pcm_rx_framer #(.SLOTS(4), .SLOT(2)) dut (
    .clk      (clk),
    .reset    (reset),
    .bclk_en  (bclk_en),
    .fs       (fs),
    .sdin     (sdin),
    .law_in   (law_in),
    .clr_ovr  (clr_ovr),
    .pcm      (bus.master),
    .locked   (locked),
    .sync_err (sync_err),
    .overrun  (overrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: queue of expected {law, code} words and flag state.
  logic [8:0] m_q[$];
  bit   m_ovr, m_serr, m_locked;
  int   m_last_i = 31;

  // Current frame being transmitted.
  logic [7:0] fr_byte[4];
  bit   fr_law[32];
  bit   fr_fs;
  int   r_mode;      // 0: ready low, 1: ready high, 2: random, 3: high only on slot-LSB bit
  bit   g_idle;
  bit   g_clr_rand;

  task automatic step(input bit b_en, input bit f, input bit d, input bit lw, input bit rdy,
                      input bit clr, input bit exp_push, input logic [8:0] exp_w, input bit exp_serr);
    bit pop, full_before, drop;
    bclk_en = b_en; fs = f; sdin = d; law_in = lw; bus.out_ready = rdy; clr_ovr = clr;
    @(posedge clk); #1;
    pop         = (m_q.size() != 0) && rdy;
    full_before = (m_q.size() == 2);
    drop        = exp_push && full_before && !pop;
    if (pop) void'(m_q.pop_front());
    if (exp_push && !drop) m_q.push_back(exp_w);
    if (drop) m_ovr = 1'b1;
    else if (clr) m_ovr = 1'b0;
    m_serr = exp_serr;
  endtask

  task automatic idle(input bit rdy, input bit clr);
    step(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
         rdy, clr, 1'b0, 9'h0, 1'b0);
  endtask

  task automatic new_frame(input logic [7:0] b, input bit lw, input bit with_fs);
    for (int k = 0; k < 4; k++) fr_byte[k] = 8'($urandom);
    fr_byte[2] = b;
    for (int i = 0; i < 32; i++) fr_law[i] = 1'($urandom_range(0, 1));
    fr_law[16] = lw;
    fr_fs = with_fs;
  endtask

  task automatic send_bits(input int from, input int to);
    for (int i = from; i <= to; i++) begin
      bit f, d, rdy, push, serr, clr;
      logic [7:0] cur;
      if (g_idle) begin
        repeat ($urandom_range(0, 2))
          idle((r_mode == 1) || (r_mode == 2 && $urandom_range(0, 1) == 1), 1'b0);
      end
      f    = fr_fs && (i == 0);
      cur  = fr_byte[i / 8];
      d    = cur[7 - (i % 8)];
      serr = f && m_locked && (m_last_i != 31);
      if (f) m_locked = 1'b1;
      push = m_locked && (i == 23);
      case (r_mode)
        0:       rdy = 1'b0;
        1:       rdy = 1'b1;
        2:       rdy = 1'($urandom_range(0, 1));
        default: rdy = push;
      endcase
      clr = g_clr_rand && ($urandom_range(0, 7) == 0);
      step(1'b1, f, d, fr_law[i], rdy, clr, push, {fr_law[16], fr_byte[2]}, serr);
      m_last_i = i;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; bclk_en = 0; fs = 0; sdin = 0; law_in = 0; clr_ovr = 0; bus.out_ready = 0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", bus.out_valid); end
    checks++; if (bus.out_s !== 8'h00) begin errors++; $display("FAIL reset_s: got %h want 00", bus.out_s); end
    checks++; if (bus.out_law !== 1'b0) begin errors++; $display("FAIL reset_law: got %b want 0", bus.out_law); end
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL reset_locked: got %b want 0", locked); end
    checks++; if (sync_err !== 1'b0) begin errors++; $display("FAIL reset_sync_err: got %b want 0", sync_err); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b want 0", overrun); end
    reset = 1'b0;
  endtask

  task automatic test_basic();
    r_mode = 0; g_idle = 1;
    new_frame(8'hA5, 1'b1, 1'b1);
    send_bits(0, 22);
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid: got %b want 0", bus.out_valid); end
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL basic_locked: got %b want 1", locked); end
    send_bits(23, 23);
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b want 1", bus.out_valid); end
    checks++; if (bus.out_s !== 8'hA5) begin errors++; $display("FAIL basic_s: got %h want a5", bus.out_s); end
    checks++; if (bus.out_law !== LAW_A) begin errors++; $display("FAIL basic_law: got %b want 1", bus.out_law); end
    checks++; if (sync_err !== 1'b0) begin errors++; $display("FAIL basic_sync_err: got %b want 0", sync_err); end
    send_bits(24, 31);
    idle(1'b1, 1'b0);
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL basic_drain: got %b want 0", bus.out_valid); end
  endtask

  task automatic test_overrun();
    logic [7:0] vals[3];
    vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33;
    r_mode = 0;
    for (int k = 0; k < 3; k++) begin
      new_frame(vals[k], 1'b0, 1'b0);
      send_bits(0, 31);
      if (k == 1) begin
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_early: got %b want 0", overrun); end
      end
    end
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_set: got %b want 1", overrun); end
    checks++; if (bus.out_s !== 8'h11) begin errors++; $display("FAIL ovr_head0: got %h want 11", bus.out_s); end
    idle(1'b1, 1'b0);
    checks++; if (bus.out_s !== 8'h22 || bus.out_valid !== 1'b1) begin errors++; $display("FAIL ovr_head1: got %h/%b want 22/1", bus.out_s, bus.out_valid); end
    idle(1'b1, 1'b0);
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL ovr_empty: got %b want 0", bus.out_valid); end
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_sticky: got %b want 1", overrun); end
    idle(1'b0, 1'b1);
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_clear: got %b want 0", overrun); end
  endtask

  task automatic test_push_pop_full();
    r_mode = 0;
    new_frame(8'h21, 1'b0, 1'b0); send_bits(0, 31);
    new_frame(8'h22, 1'b0, 1'b0); send_bits(0, 31);
    checks++; if (bus.out_s !== 8'h21) begin errors++; $display("FAIL ppf_head: got %h want 21", bus.out_s); end
    r_mode = 3;
    new_frame(8'h44, 1'b1, 1'b0); send_bits(0, 31);
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ppf_no_ovr: got %b want 0", overrun); end
    checks++; if (bus.out_s !== 8'h22) begin errors++; $display("FAIL ppf_pop1: got %h want 22", bus.out_s); end
    idle(1'b1, 1'b0);
    checks++; if (bus.out_s !== 8'h44 || bus.out_law !== 1'b1) begin errors++; $display("FAIL ppf_pop2: got %h/%b want 44/1", bus.out_s, bus.out_law); end
    idle(1'b1, 1'b0);
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL ppf_empty: got %b want 0", bus.out_valid); end
  endtask

  task automatic test_law_latch();
    logic [7:0] b;
    b = 8'($urandom);
    r_mode = 0;
    new_frame(b, 1'b0, 1'b0);
    for (int i = 16; i < 24; i++) fr_law[i] = (i >= 20);
    send_bits(0, 31);
    checks++; if (bus.out_law !== LAW_U) begin errors++; $display("FAIL law_latch: got %b want 0", bus.out_law); end
    checks++; if (bus.out_s !== b) begin errors++; $display("FAIL law_code: got %h want %h", bus.out_s, b); end
    idle(1'b1, 1'b0);
  endtask

  task automatic test_sync_err();
    int cut[2];
    logic [7:0] good[2];
    cut[0] = 12; cut[1] = 19; good[0] = 8'hC3; good[1] = 8'h3C;
    r_mode = 0;
    for (int k = 0; k < 2; k++) begin
      new_frame(8'h5A, 1'b1, 1'b0);
      send_bits(0, cut[k]);
      new_frame(good[k], 1'b1, 1'b1);
      send_bits(0, 0);
      checks++; if (sync_err !== 1'b1) begin errors++; $display("FAIL sync_pulse_%0d: got %b want 1", k, sync_err); end
      send_bits(1, 1);
      checks++; if (sync_err !== 1'b0) begin errors++; $display("FAIL sync_clear_%0d: got %b want 0", k, sync_err); end
      send_bits(2, 22);
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL sync_partial_%0d: got %b want 0", k, bus.out_valid); end
      send_bits(23, 31);
      checks++; if (bus.out_s !== good[k] || bus.out_valid !== 1'b1) begin errors++; $display("FAIL sync_next_%0d: got %h/%b want %h/1", k, bus.out_s, bus.out_valid, good[k]); end
      idle(1'b1, 1'b0);
    end
  endtask

  task automatic test_reset_mid();
    r_mode = 0;
    new_frame(8'hB1, 1'b1, 1'b0); send_bits(0, 31);
    new_frame(8'hB2, 1'b1, 1'b0); send_bits(0, 18);
    #2 reset = 1'b1;
    #1;
    checks++; if (bus.out_valid !== 1'b0 || bus.out_s !== 8'h00 || bus.out_law !== 1'b0) begin errors++; $display("FAIL rst_mid_out: got %b/%h/%b want 0/00/0", bus.out_valid, bus.out_s, bus.out_law); end
    checks++; if (locked !== 1'b0 || sync_err !== 1'b0 || overrun !== 1'b0) begin errors++; $display("FAIL rst_mid_flags: got %b%b%b want 000", locked, sync_err, overrun); end
    m_q.delete(); m_ovr = 0; m_serr = 0; m_locked = 0; m_last_i = 31;
    @(posedge clk); #1 reset = 1'b0;
    new_frame(8'hB3, 1'b1, 1'b0); send_bits(0, 31);
    checks++; if (bus.out_valid !== 1'b0 || locked !== 1'b0) begin errors++; $display("FAIL rst_no_capture: got %b/%b want 0/0", bus.out_valid, locked); end
    new_frame(8'hB4, 1'b0, 1'b1); send_bits(0, 31);
    checks++; if (bus.out_s !== 8'hB4 || bus.out_valid !== 1'b1) begin errors++; $display("FAIL rst_recover: got %h/%b want b4/1", bus.out_s, bus.out_valid); end
    idle(1'b1, 1'b0);
  endtask

  task automatic test_random();
    bit need_fs = 0;
    r_mode = 2; g_idle = 1; g_clr_rand = 1;
    for (int n = 0; n < 40; n++) begin
      int last;
      bit with_fs;
      with_fs = need_fs || ($urandom_range(0, 3) == 0);
      last    = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 30)) : 31;
      need_fs = (last != 31);
      new_frame(8'($urandom), 1'($urandom_range(0, 1)), with_fs);
      for (int i = 0; i <= last; i++) begin
        send_bits(i, i);
        checks++; if (bus.out_valid !== (m_q.size() != 0)) begin errors++; $display("FAIL rnd_valid f%0d b%0d: got %b want %b", n, i, bus.out_valid, m_q.size() != 0); end
        if (m_q.size() != 0) begin
          checks++; if ({bus.out_law, bus.out_s} !== m_q[0]) begin errors++; $display("FAIL rnd_word f%0d b%0d: got %h want %h", n, i, {bus.out_law, bus.out_s}, m_q[0]); end
        end
        checks++; if (overrun !== m_ovr) begin errors++; $display("FAIL rnd_overrun f%0d b%0d: got %b want %b", n, i, overrun, m_ovr); end
        checks++; if (sync_err !== m_serr) begin errors++; $display("FAIL rnd_sync_err f%0d b%0d: got %b want %b", n, i, sync_err, m_serr); end
        checks++; if (locked !== m_locked) begin errors++; $display("FAIL rnd_locked f%0d b%0d: got %b want %b", n, i, locked, m_locked); end
      end
    end
    g_clr_rand = 0;
  endtask

  initial begin
    g_clr_rand = 0;
    test_reset();
    test_basic();
    test_overrun();
    test_push_pop_full();
    test_law_latch();
    test_sync_err();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pcm_rx_framer.md
# pcm_rx_framer

Serial PCM receive framer that sits directly upstream of the EXPAND stage in the MCAC datapath. Recovers 8-bit companded PCM codewords for one selected timeslot from a TDM serial stream (frame sync + bit strobe), tags each with the active companding law, and buffers them in a 2-entry FIFO. Presents them to EXPAND over a valid/ready handshake. Reports frame-sync errors and FIFO overrun.

## Interface
Parameters:
- SLOTS, 32, timeslots per TDM frame (≥1)
- SLOT, 0, timeslot index captured (0..SLOTS-1)

Ports:
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  asynchronous, active-high reset
- bclk_en  in  1  one-cycle strobe marking a valid serial bit
- fs  in  1  frame sync; sampled only when bclk_en=1
- sdin  in  1  serial PCM data, MSB first; sampled only when bclk_en=1
- law_in  in  1  companding law (1 = A-law, 0 = µ-law), latched per word
- clr_ovr  in  1  clears sticky overrun flag
- out_valid  out  1  FIFO head holds a word
- out_ready  in  1  EXPAND accepts the word
- out_s  out  8  PCM codeword at FIFO head
- out_law  out  1  law tag at FIFO head
- locked  out  1  first fs has been seen
- sync_err  out  1  one-cycle pulse on unexpected fs
- overrun  out  1  sticky: a word was dropped because the FIFO was full

## Operation
- Reset values: out_valid=0, out_s=8'h00, out_law=0, locked=0, sync_err=0, overrun=0. Bit counter=0. FIFO empty.
- Bit counter bcnt: range 0..SLOTS*8-1; advances only on bclk_en.
- fs=1 with bclk_en: that sdin bit is bit 7 of slot 0 (bcnt forced to 0). locked←1.
- No fs: bcnt wraps from SLOTS*8-1 to 0 (free-run).
- fs arriving when bcnt≠SLOTS*8-1 (i.e. the next position would not be 0), while locked=1:
  - sync_err pulses for one cycle.
  - bcnt is resynced to 0.
  - Any partially shifted word is discarded.
- While locked=0, nothing is captured. The first fs never raises sync_err.
- Capture window is bcnt in SLOT*8 .. SLOT*8+7:
  - sdin shifts into an 8-bit shift register, MSB first.
  - law_in is latched on the window's first bit (bcnt=SLOT*8); mid-word changes are ignored.
- On the bit at bcnt=SLOT*8+7, the {law, code} word is pushed to the FIFO.
- FIFO: depth 2, first-word-fall-through.
  - Pop occurs when out_valid & out_ready.
  - Push while full and no pop: the new word is dropped, overrun←1, FIFO contents unchanged.
  - Push while full with a simultaneous pop: the push is accepted and no overrun occurs.
- overrun clears only on reset or clr_ovr. If clr_ovr coincides with a new overrun event, set wins.
- out_s/out_law are stable while out_valid=1 and out_ready=0.

## Timing
- out_valid rises on the clk edge after the bclk_en cycle that carries bit 0 (LSB) of the selected slot. Latency is 1 clk.
- A pop on edge N exposes the second entry, or deasserts out_valid, on edge N.
- sync_err is registered: it asserts on the clk edge after the offending fs sample.
- Asserting reset mid-word or mid-handshake clears state immediately (asynchronously). The partial word is lost. Capture resumes only after the next fs.
- bclk_en may be high on consecutive cycles; there is no minimum spacing.
- out_ready may toggle every cycle.

## Structure
- Shared package mcac_pkg holds:
  - PCM_W=8.
  - Typedef pcm_word_t {logic law; logic [7:0] code}.
  - LAW_A=1'b1 and LAW_U=1'b0.
- EXPAND consumes pcm_word_t fields from the same package.
- One sub-module, pcm_fifo2: a 2-entry FWFT FIFO of pcm_word_t.
  - Signals: push, pop, full, empty, head.
  - It implements the simultaneous push/pop-when-full rule.
- The framer top holds the counter, shift register, law latch and flags.

## Test plan
- SLOTS=4, SLOT=2: fs, then 32 bits with slot 2 = 8'hA5 and law_in=1. Expect out_valid one clk after the slot-2 LSB, out_s=8'hA5, out_law=1, sync_err=0.
- out_ready held 0 across three frames carrying 8'h11, 8'h22, 8'h33:
  - FIFO holds 8'h11 and 8'h22.
  - overrun=1 after the third word.
  - Releasing out_ready yields 11 then 22.
  - clr_ovr then clears overrun.
- FIFO full and out_ready=1 exactly on the push cycle of 8'h44: expect no overrun, and pop order 22, 44.
- fs injected at bcnt=13 mid-frame: sync_err pulses for 1 clk, the partial slot word is never emitted, and the next full frame's slot word emits correctly.
- law_in toggled 0→1 at bit 3 of the slot: the emitted word has out_law=0 (the value latched at bit 7).
- reset asserted at bit 4 of the slot with one word in the FIFO: all outputs go to reset values immediately. After release and before fs, no words are emitted and locked=0.
